ethtx_preamble: RTL and testbench



---
 rtl/ethtx_preamble.sv | 122 ++++++++++++
 tb/tb_ethtx_preamble.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ethtx_preamble.sv
// Ethernet TX preamble/SFD inserter with inter-packet-gap enforcement for
// MII (DW=4) or GMII (DW=8) datapaths; upstream is stalled during preamble and gap.
module ethtx_preamble #(
  parameter int DW              = 4,
  parameter int PREAMBLE_OCTETS = 7,
  parameter int IPG_OCTETS      = 12
) (
  input  logic          i_clk,
  input  logic          i_areset_n,
  input  logic          i_ce,
  input  logic          i_en,
  input  logic          i_cancel,
  input  logic          i_v,
  input  logic [DW-1:0] i_d,
  output logic          o_ready,
  output logic          o_v,
  output logic [DW-1:0] o_d,
  output logic          o_busy
);

  localparam int BPO  = 8 / DW;
  localparam int NPRE = (PREAMBLE_OCTETS + 1) * BPO;
  localparam int NGAP = IPG_OCTETS * BPO;
  localparam int NMAX = (NPRE > NGAP) ? NPRE : NGAP;
  localparam int CW   = $clog2(NMAX + 1);

  generate
    if (DW != 4 && DW != 8) begin : g_bad_dw
      $error("ethtx_preamble: DW must be 4 or 8");
    end
    if (IPG_OCTETS < 1) begin : g_bad_ipg
      $error("ethtx_preamble: IPG_OCTETS must be at least 1");
    end
  endgenerate

  localparam logic [7:0]    PRE_OCT  = 8'h55;
  localparam logic [7:0]    SFD_OCT  = 8'hD5;
  // MII sends the low nibble first, so the final SFD nibble is the high one.
  localparam logic [DW-1:0] PRE_BEAT = PRE_OCT[DW-1:0];
  localparam logic [DW-1:0] SFD_BEAT = SFD_OCT[7 -: DW];
  localparam logic [CW-1:0] PRE_LAST = CW'(NPRE - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(NGAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_GAP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            v_q, v_d;
  logic [DW-1:0]   d_q, d_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    v_d     = v_q;
    d_d     = d_q;
    case (state_q)
      S_IDLE: begin
        v_d = 1'b0;
        d_d = '0;
        if (i_v) begin
          if (i_en) begin
            v_d     = 1'b1;
            d_d     = (NPRE == 1) ? SFD_BEAT : PRE_BEAT;
            cnt_d   = CW'(1);
            state_d = (NPRE == 1) ? S_DATA : S_PRE;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_PRE: begin
        if (i_cancel) begin
          v_d     = 1'b0;
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          v_d   = 1'b1;
          d_d   = (cnt_q == PRE_LAST) ? SFD_BEAT : PRE_BEAT;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == PRE_LAST) state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (i_cancel || !i_v) begin
          v_d     = 1'b0;
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          v_d = 1'b1;
          d_d = i_d;
        end
      end
      S_GAP: begin
        // Cancel is deliberately ignored here: the gap never restarts.
        v_d   = 1'b0;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == GAP_LAST) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      v_q     <= 1'b0;
      d_q     <= '0;
    end else if (i_ce) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v_q     <= v_d;
      d_q     <= d_d;
    end
  end

  assign o_ready = (state_q == S_DATA);
  assign o_busy  = (state_q != S_IDLE);
  assign o_v     = v_q;
  assign o_d     = d_q;

endmodule

// File: tb/tb_ethtx_preamble.sv
// Randomised bench for ethtx_preamble: per-ce-edge timeline model for DW=4 and
// DW=8 instances, plus literal checks on the canonical packets.
module tb_ethtx_preamble;

  localparam int NPRE4 = (7 + 1) * (8 / 4);
  localparam int NGAP4 = 12 * (8 / 4);
  localparam int NPRE8 = (7 + 1) * (8 / 8);
  localparam int NGAP8 = 12 * (8 / 8);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;
  logic en4 = 1'b0, cancel4 = 1'b0, v4 = 1'b0;
  logic [3:0] d4 = '0;
  logic rdy4, ov4, busy4;
  logic [3:0] od4;
  logic en8 = 1'b0, cancel8 = 1'b0, v8 = 1'b0;
  logic [7:0] d8 = '0;
  logic rdy8, ov8, busy8;
  logic [7:0] od8;

  always #5 clk = ~clk;

  ethtx_preamble #(.DW(4), .PREAMBLE_OCTETS(7), .IPG_OCTETS(12)) u4 (
    .i_clk(clk), .i_areset_n(rst_n), .i_ce(ce), .i_en(en4), .i_cancel(cancel4),
    .i_v(v4), .i_d(d4), .o_ready(rdy4), .o_v(ov4), .o_d(od4), .o_busy(busy4));

  ethtx_preamble #(.DW(8), .PREAMBLE_OCTETS(7), .IPG_OCTETS(12)) u8 (
    .i_clk(clk), .i_areset_n(rst_n), .i_ce(ce), .i_en(en8), .i_cancel(cancel8),
    .i_v(v8), .i_d(d8), .o_ready(rdy8), .o_v(ov8), .o_d(od8), .o_busy(busy8));

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;
  logic ev[2], er[2], eb[2], nv[2], nr[2], nb[2];
  logic [7:0] ed[2], nd[2];
  logic [7:0] pkt[$];
  logic [7:0] mq[$];
  int mgap = 0;
  bit mon_on = 0;
  int mon_inst = 0;

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  // Per-clock comparison against the expected state after the last ce edge.
  always @(negedge clk) if (chk_on) begin
    cmp("o_v4",    {7'd0, ov4},   {7'd0, ev[0]});
    cmp("o_ready4",{7'd0, rdy4},  {7'd0, er[0]});
    cmp("o_busy4", {7'd0, busy4}, {7'd0, eb[0]});
    if (ev[0]) cmp("o_d4", {4'd0, od4}, ed[0]);
    cmp("o_v8",    {7'd0, ov8},   {7'd0, ev[1]});
    cmp("o_ready8",{7'd0, rdy8},  {7'd0, er[1]});
    cmp("o_busy8", {7'd0, busy8}, {7'd0, eb[1]});
    if (ev[1]) cmp("o_d8", od8, ed[1]);
  end

  always @(posedge clk) if (rst_n && ce) begin
    for (int k = 0; k < 2; k++) begin
      ev[k] = nv[k]; er[k] = nr[k]; eb[k] = nb[k]; ed[k] = nd[k];
    end
  end

  always @(negedge clk) if (mon_on) begin
    if (mon_inst == 0) begin
      if (ov4) mq.push_back({4'd0, od4});
      if (busy4 && !ov4) mgap++;
    end else begin
      if (ov8) mq.push_back(od8);
      if (busy8 && !ov8) mgap++;
    end
  end

  function automatic logic [7:0] pre_beat(input int inst, input int j);
    if (inst == 0) return (j == NPRE4 - 1) ? 8'h0D : 8'h05;
    return (j == NPRE8 - 1) ? 8'hD5 : 8'h55;
  endfunction

  task automatic drive(input int inst, input logic v, input logic [7:0] d,
                       input logic c, input logic e);
    if (inst == 0) begin v4 = v; d4 = d[3:0]; cancel4 = c; en4 = e; end
    else begin v8 = v; d8 = d; cancel8 = c; en8 = e; end
  endtask

  task automatic zero_exp();
    for (int k = 0; k < 2; k++) begin
      ev[k] = 0; er[k] = 0; eb[k] = 0; ed[k] = 0;
      nv[k] = 0; nr[k] = 0; nb[k] = 0; nd[k] = 0;
    end
  endtask

  task automatic do_reset_mid(input int inst);
    #2 rst_n = 1'b0;
    zero_exp();
    #1;
    if (inst == 0) begin
      cmp("rst_o_v4", {7'd0, ov4}, 8'd0); cmp("rst_o_d4", {4'd0, od4}, 8'd0);
      cmp("rst_busy4", {7'd0, busy4}, 8'd0); cmp("rst_ready4", {7'd0, rdy4}, 8'd0);
    end else begin
      cmp("rst_o_v8", {7'd0, ov8}, 8'd0); cmp("rst_o_d8", od8, 8'd0);
      cmp("rst_busy8", {7'd0, busy8}, 8'd0); cmp("rst_ready8", {7'd0, rdy8}, 8'd0);
    end
    drive(inst, 1'b0, 8'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Edge j counts ce edges from the one on which IDLE sees i_v. Header edges
  // 0..L-1, data edges L..E-1, end/cancel edge E, gap until E+NGAP.
  task automatic run_pkt(input int inst, input bit en, input int cancel_at,
                         input int ce_mode, input int tail, input int rst_at);
    int n, np, ng, L, E, last, j;
    bit tog;
    logic lv, lc, le;
    logic [7:0] ld;
    n = pkt.size();
    np = (inst == 0) ? NPRE4 : NPRE8;
    ng = (inst == 0) ? NGAP4 : NGAP8;
    L = en ? np : 1;
    E = (cancel_at >= 0) ? cancel_at : L + n;
    last = E + ng + tail;
    j = 0;
    tog = 0;
    while (j <= last) begin
      @(negedge clk); #1;
      if (j == rst_at) begin
        do_reset_mid(inst);
        pkt.delete();
        return;
      end
      case (ce_mode)
        0: ce = 1'b1;
        1: begin tog = ~tog; ce = tog; end
        default: ce = (($urandom % 4) != 0);
      endcase
      if (!ce) begin
        drive(inst, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        continue;
      end
      ld = 8'($urandom); lc = 1'b0; le = 1'($urandom);
      if (j == 0) le = en;
      if (j < E) begin
        lv = 1'b1;
        if (j >= L) ld = pkt[j-L];
        if (j == 0) lc = 1'($urandom);
      end else if (j == E) begin
        lv = (cancel_at >= 0) ? 1'($urandom) : 1'b0;
        lc = (cancel_at >= 0) ? 1'b1 : 1'($urandom);
      end else begin
        lv = 1'b0;
        lc = 1'($urandom);
      end
      drive(inst, lv, ld, lc, le);
      if (j < E && j < L) begin
        nv[inst] = en; nd[inst] = pre_beat(inst, j); nr[inst] = (j == L - 1); nb[inst] = 1;
      end else if (j < E) begin
        nv[inst] = 1; nd[inst] = pkt[j-L]; nr[inst] = 1; nb[inst] = 1;
      end else if (j < E + ng) begin
        nv[inst] = 0; nd[inst] = 0; nr[inst] = 0; nb[inst] = 1;
      end else begin
        nv[inst] = 0; nd[inst] = 0; nr[inst] = 0; nb[inst] = 0;
      end
      j++;
    end
    pkt.delete();
  endtask

  task automatic fill_pkt(input int inst, input int n);
    for (int i = 0; i < n; i++)
      pkt.push_back(inst == 0 ? {4'd0, 4'($urandom)} : 8'($urandom));
  endtask

  initial begin
    logic [7:0] lit4[19];
    logic [7:0] lit8[10];
    int inst, n, L, ca;
    bit en;
    zero_exp();
    repeat (3) @(negedge clk);
    cmp("reset_o_v4", {7'd0, ov4}, 8'd0);  cmp("reset_o_d4", {4'd0, od4}, 8'd0);
    cmp("reset_ready4", {7'd0, rdy4}, 8'd0); cmp("reset_busy4", {7'd0, busy4}, 8'd0);
    cmp("reset_o_v8", {7'd0, ov8}, 8'd0);  cmp("reset_o_d8", od8, 8'd0);
    cmp("reset_ready8", {7'd0, rdy8}, 8'd0); cmp("reset_busy8", {7'd0, busy8}, 8'd0);
    rst_n = 1'b1;
    chk_on = 1;

    // Canonical MII packet 1,2,3 with literal expectations.
    for (int i = 0; i < 15; i++) lit4[i] = 8'h05;
    lit4[15] = 8'h0D; lit4[16] = 8'h01; lit4[17] = 8'h02; lit4[18] = 8'h03;
    mq.delete(); mgap = 0; mon_inst = 0; mon_on = 1;
    pkt = '{8'h01, 8'h02, 8'h03};
    run_pkt(0, 1'b1, -1, 0, 2, -1);
    mon_on = 0;
    cmp("lit4_count", 8'(mq.size()), 8'd19);
    cmp("lit4_gap", 8'(mgap), 8'd24);
    if (mq.size() == 19) for (int i = 0; i < 19; i++) cmp("lit4_beat", mq[i], lit4[i]);

    pkt = '{8'h01, 8'h02, 8'h03};
    run_pkt(0, 1'b1, -1, 1, 2, -1);
    pkt = '{8'h0A, 8'h0B, 8'h0C};
    run_pkt(0, 1'b0, -1, 0, 1, -1);

    // Cancel on the 6th preamble beat, then a back-to-back packet.
    fill_pkt(0, 4);
    run_pkt(0, 1'b1, 6, 0, 0, -1);
    fill_pkt(0, 3);
    run_pkt(0, 1'b1, -1, 0, 2, -1);

    // Canonical GMII packet.
    for (int i = 0; i < 7; i++) lit8[i] = 8'h55;
    lit8[7] = 8'hD5; lit8[8] = 8'hAB; lit8[9] = 8'hCD;
    mq.delete(); mgap = 0; mon_inst = 1; mon_on = 1;
    pkt = '{8'hAB, 8'hCD};
    run_pkt(1, 1'b1, -1, 0, 2, -1);
    mon_on = 0;
    cmp("lit8_count", 8'(mq.size()), 8'd10);
    cmp("lit8_gap", 8'(mgap), 8'd12);
    if (mq.size() == 10) for (int i = 0; i < 10; i++) cmp("lit8_beat", mq[i], lit8[i]);

    // Reset in the middle of a 100-beat packet, then a fresh packet.
    fill_pkt(0, 100);
    run_pkt(0, 1'b1, -1, 0, 0, NPRE4 + 50);
    fill_pkt(0, 2);
    run_pkt(0, 1'b1, -1, 0, 2, -1);

    repeat (30) begin
      inst = int'($urandom % 2);
      en = 1'($urandom);
      n = int'($urandom_range(1, 6));
      L = en ? (inst == 0 ? NPRE4 : NPRE8) : 1;
      ca = (($urandom % 3) == 0) ? int'($urandom_range(1, L + n - 1)) : -1;
      fill_pkt(inst, n);
      run_pkt(inst, en, ca, int'($urandom % 3), int'($urandom % 3), -1);
    end

    @(negedge clk);
    chk_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
